cpu_trace_buffer: RTL and testbench
===================================

# cpu_trace_buffer

Trace capture stage that sits directly downstream of `CPU` and consumes its `addr` (current PC) and `result` (writeback value) outputs every clock. Once armed, it waits for a trigger PC and then records up to DEPTH distinct (addr, result) pairs into an internal FIFO. A valid/ready read port drains the FIFO into a display or UART stage. Overflow is counted, never stalls the CPU.

## Interface
- DEPTH, 16, FIFO entries and capture limit; power of 2, ≥4
- AW, 4, log2(DEPTH)
- FILTER_DUP, 1, 1 = skip a sample whose addr equals the previous sampled addr (multi-cycle or stalled instruction)

- Clock  in  1  rising-edge clock, same as CPU
- Reset  in  1  asynchronous, active-high; clears all state
- addr  in  32  CPU PC
- result  in  32  CPU result bus
- arm  in  1  one-cycle pulse; IDLE/DONE → ARMED
- clear  in  1  synchronous flush → IDLE
- trig_addr  in  32  PC that starts capture
- rd_ready  in  1  consumer accepts head entry
- rd_valid  out  1  FIFO non-empty
- rd_addr  out  32  head entry addr; 0 when rd_valid=0
- rd_result  out  32  head entry result; 0 when rd_valid=0
- count  out  AW+1  entries held, 0..DEPTH
- state  out  2  IDLE=0, ARMED=1, RUN=2, DONE=3
- overflow  out  1  sticky; set when a sample was dropped on full
- drop_cnt  out  16  dropped samples, saturates at 16'hFFFF

## Operation
- Reset values: state=IDLE, count=0, rd_valid=0, rd_addr=rd_result=0, overflow=0, drop_cnt=0, read/write pointers 0, sample counter 0, last-addr-valid=0.
- IDLE: no sampling. arm → ARMED.
- ARMED: each edge compare addr with trig_addr; on match → RUN and that same sample is taken.
- RUN: one sample per edge. With FILTER_DUP=1, sample skipped (not stored, not counted) when addr equals previous sampled addr; last-addr-valid cleared on entering RUN so the trigger sample is never filtered.
- Each taken sample increments the sample counter; if FIFO not full (after same-cycle pop) it is written, else dropped: drop_cnt+1 (saturating), overflow=1.
- When sample counter reaches DEPTH → DONE. Sampling stops; FIFO remains readable.
- DONE: arm → ARMED, resets sample counter; FIFO contents, overflow and drop_cnt kept.
- arm in ARMED or RUN ignored.
- clear (any state): → IDLE, pointers/count to 0, overflow=0, drop_cnt=0, sample counter 0. clear beats arm and any same-cycle push/pop.
- Read: pop when rd_valid && rd_ready; head advances at that edge. rd_ready with rd_valid=0 has no effect.
- Simultaneous push and pop: count unchanged; when full, pop frees the slot and the push is accepted (no drop).
- Pointers are AW bits and wrap modulo DEPTH; count is the full/empty discriminator (full = count==DEPTH).

## Timing
- Sample taken at edge N appears on rd_* with rd_valid=1 after edge N (1-cycle latency); count updates at the same edge.
- ARMED→RUN transition and the trigger-sample write occur at the same edge.
- rd_addr/rd_result are a combinational read of the head entry, stable whilst rd_valid=1 and rd_ready=0.
- overflow/drop_cnt update at the edge of the dropped sample.
- Reset asserted mid-RUN clears all outputs immediately, without waiting for Clock; first capture after release requires a new arm.

## Test plan
- Reset, arm, trig_addr=0x0000_0008, PC sequence 0,4,8,C,10 with rd_ready=1 → first entry addr=0x8; entries 0x8, 0xC, 0x10 in order; state=RUN.
- FILTER_DUP=1, in RUN PC held at 0x14 for 3 cycles then 0x18 → exactly two entries (0x14, 0x18); sample counter +2.
- rd_ready=0, DEPTH=16 distinct PCs after trigger → count=16, state=DONE, overflow=0; 17th PC ignored (DONE).
- rd_ready=0, fill FIFO, re-arm in DONE, trigger again with 3 further PCs → 3 drops, drop_cnt=3, overflow=1, count=16; then pulse clear → count=0, overflow=0, drop_cnt=0, state=IDLE.
- Full FIFO in RUN, rd_ready=1 same cycle as new sample → no drop, count stays 16, head advances by one.
- Assert Reset asynchronously between edges during RUN with count=5 → count=0, rd_valid=0, state=IDLE before next Clock edge.

Source files
------------

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: arms on a trigger PC, then captures up to DEPTH distinct
// (addr, result) pairs from the CPU into a FIFO drained by a valid/ready port.
// Samples that find the FIFO full are dropped and counted; the CPU never stalls.
//
// state | meaning
// IDLE  | no sampling, waiting for arm
// ARMED | comparing addr against trig_addr every edge
// RUN   | one sample per edge until DEPTH samples have been taken
// DONE  | capture finished, FIFO still readable, arm restarts
module cpu_trace_buffer #(
  parameter int DEPTH      = 16,
  parameter int AW         = 4,
  parameter int FILTER_DUP = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   addr,
  input  logic [31:0]   result,
  input  logic          arm,
  input  logic          clear,
  input  logic [31:0]   trig_addr,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [31:0]   rd_addr,
  output logic [31:0]   rd_result,
  output logic [AW:0]   count,
  output logic [1:0]    state,
  output logic          overflow,
  output logic [15:0]   drop_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  state_t        state_q, state_d;
  logic [31:0]   mem_addr   [DEPTH];
  logic [31:0]   mem_result [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_q, samp_cnt;
  logic [31:0]   last_addr;
  logic          last_valid;
  logic          ovf_q;
  logic [15:0]   drop_q;

  logic trig_hit, dup, take, pop, full_eff, push, drop, samp_last;

  // Sample qualification and FIFO push/pop/drop decisions for this edge.
  always_comb begin
    trig_hit  = (state_q == S_ARMED) && (addr == trig_addr);
    dup       = (FILTER_DUP != 0) && last_valid && (addr == last_addr);
    take      = trig_hit || ((state_q == S_RUN) && !dup);
    pop       = rd_valid && rd_ready;
    // a same-cycle pop frees the slot, so a full FIFO can still accept
    full_eff  = (count_q == FULL_CNT) && !pop;
    push      = take && !full_eff;
    drop      = take && full_eff;
    samp_last = take && ((samp_cnt + ONE_CNT) == FULL_CNT);
  end

  // Next-state logic; clear overrides everything, including arm.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (arm) state_d = S_ARMED;
        S_ARMED: if (trig_hit) state_d = samp_last ? S_DONE : S_RUN;
        S_RUN:   if (samp_last) state_d = S_DONE;
        S_DONE:  if (arm) state_d = S_ARMED;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State register, FIFO bookkeeping, sample counter and drop statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      samp_cnt   <= '0;
      last_addr  <= '0;
      last_valid <= 1'b0;
      ovf_q      <= 1'b0;
      drop_q     <= '0;
    end else if (clear) begin
      state_q    <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      samp_cnt   <= '0;
      last_valid <= 1'b0;
      ovf_q      <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count_q <= count_q + ONE_CNT;
      else if (!push && pop) count_q <= count_q - ONE_CNT;
      if (state_d == S_ARMED && state_q != S_ARMED) samp_cnt <= '0;
      else if (take)                                samp_cnt <= samp_cnt + ONE_CNT;
      // a dropped sample still counts as the previous sample for filtering
      if (take) begin
        last_addr  <= addr;
        last_valid <= 1'b1;
      end else if (state_q != S_RUN) begin
        last_valid <= 1'b0;
      end
      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      end
    end
  end

  // FIFO storage; pointers carry the reset, the array does not need one.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem_addr[wr_ptr]   <= addr;
      mem_result[wr_ptr] <= result;
    end
  end

  assign rd_valid  = (count_q != '0);
  assign rd_addr   = rd_valid ? mem_addr[rd_ptr]   : 32'd0;
  assign rd_result = rd_valid ? mem_result[rd_ptr] : 32'd0;
  assign count     = count_q;
  assign state     = state_q;
  assign overflow  = ovf_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Testbench for cpu_trace_buffer: directed PC sequences, expected FIFO entries
// queued at stimulus time and checked by an independent read-port monitor.
module tb_cpu_trace_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, result, trig_addr;
  logic        arm, clear, rd_ready;
  logic        rd_valid;
  logic [31:0] rd_addr, rd_result;
  logic [4:0]  count;
  logic [1:0]  state;
  logic        overflow;
  logic [15:0] drop_cnt;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb [$];

  cpu_trace_buffer #(.DEPTH(16), .AW(4), .FILTER_DUP(1)) dut (
    .clk(clk), .rst(rst), .addr(addr), .result(result), .arm(arm),
    .clear(clear), .trig_addr(trig_addr), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_result(rd_result),
    .count(count), .state(state), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] res_of(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // drive one PC for one clock; optionally record it as an expected capture
  task automatic step(input logic [31:0] pc, input bit expect_push);
    addr   = pc;
    result = res_of(pc);
    if (expect_push) sb.push_back({pc, res_of(pc)});
    @(posedge clk);
    #1;
  endtask

  // monitor: every accepted read must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst && rd_valid && rd_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected: got %h/%h expected nothing", rd_addr, rd_result);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        if ({rd_addr, rd_result} !== e) begin
          bad++;
          $display("FAIL rd_entry: got %h/%h expected %h/%h",
                   rd_addr, rd_result, e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; arm = 1'b0; clear = 1'b0; rd_ready = 1'b0;
    addr = '0; result = '0; trig_addr = '0;
    #2;
    chk("rst_state", 32'(state), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_addr", rd_addr, 0);
    chk("rst_result", rd_result, 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // trigger at 0x8, continuous draining
    trig_addr = 32'h8; rd_ready = 1'b1;
    arm = 1'b1; step(32'h0, 0); arm = 1'b0;
    step(32'h0, 0); step(32'h4, 0);
    step(32'h8, 1); step(32'hC, 1); step(32'h10, 1);
    chk("t1_state_run", 32'(state), 2);
    step(32'h10, 0); step(32'h10, 0);
    chk("t1_count", 32'(count), 0);

    // duplicate filtering then run to the capture limit (5 + 11 = 16)
    step(32'h14, 1); step(32'h14, 0); step(32'h14, 0); step(32'h18, 1);
    for (int i = 0; i < 10; i++) step(32'h1C + 32'(4*i), 1);
    chk("t2_state_run", 32'(state), 2);
    step(32'h44, 1);
    chk("t2_state_done", 32'(state), 3);
    step(32'h48, 0);
    chk("t2_count", 32'(count), 0);
    chk("t2_sb_drained", 32'(sb.size()), 0);

    // fill with no reads
    rd_ready = 1'b0;
    clear = 1'b1; step(32'h48, 0); clear = 1'b0;
    trig_addr = 32'h100;
    arm = 1'b1; step(32'h48, 0); arm = 1'b0;
    for (int i = 0; i < 16; i++) step(32'h100 + 32'(4*i), 1);
    chk("t3_count", 32'(count), 16);
    chk("t3_state", 32'(state), 3);
    chk("t3_ovf", 32'(overflow), 0);
    step(32'h140, 0);
    chk("t3_count_17", 32'(count), 16);
    chk("t3_state_17", 32'(state), 3);

    // re-arm on full FIFO: pop and push on the trigger edge, then drops
    trig_addr = 32'h200;
    arm = 1'b1; step(32'h140, 0); arm = 1'b0;
    rd_ready = 1'b1; step(32'h200, 1); rd_ready = 1'b0;
    chk("t5_count", 32'(count), 16);
    chk("t5_drop", 32'(drop_cnt), 0);
    chk("t5_head", rd_addr, 32'h104);
    step(32'h204, 0); step(32'h208, 0); step(32'h20C, 0);
    chk("t4_drop", 32'(drop_cnt), 3);
    chk("t4_ovf", 32'(overflow), 1);
    chk("t4_count", 32'(count), 16);
    chk("t4_state", 32'(state), 2);
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) step(32'h20C, 0);
    rd_ready = 1'b0;
    chk("t4_count_drain", 32'(count), 12);
    clear = 1'b1; step(32'h20C, 0); clear = 1'b0;
    sb.delete();
    chk("clr_count", 32'(count), 0);
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_drop", 32'(drop_cnt), 0);
    chk("clr_state", 32'(state), 0);
    chk("clr_valid", 32'(rd_valid), 0);

    // asynchronous reset mid-run
    trig_addr = 32'h300;
    arm = 1'b1; step(32'h0, 0); arm = 1'b0;
    for (int i = 0; i < 5; i++) step(32'h300 + 32'(4*i), 1);
    chk("t6_count", 32'(count), 5);
    chk("t6_state", 32'(state), 2);
    @(negedge clk); #1; rst = 1'b1; #1;
    chk("t6_rst_count", 32'(count), 0);
    chk("t6_rst_valid", 32'(rd_valid), 0);
    chk("t6_rst_state", 32'(state), 0);
    chk("t6_rst_addr", rd_addr, 0);
    sb.delete();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    step(32'h300, 0); step(32'h304, 0);
    chk("t6_noarm_state", 32'(state), 0);
    chk("t6_noarm_count", 32'(count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
